// File: rtl/spm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_pkg
// Description : Shared constants, types and helpers for serial_pattern_matcher.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_pkg;

  // Largest supported pattern length
  localparam int SPM_N_MAX = 32;

  // All-compare mask at maximum width; truncated to N bits by users
  localparam logic [SPM_N_MAX-1:0] SPM_MASK_ALL = {SPM_N_MAX{1'b1}};

  // Overlap mode as seen on the overlap input
  typedef enum logic {
    SPM_NONOVL = 1'b0,
    SPM_OVL    = 1'b1
  } spm_ovl_e;

  // Width needed for a fill counter that must hold the value n
  function automatic int spm_fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spm_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : spm_sat_counter
// Description : Generic W-bit saturating up-counter with synchronous clear.
//               Clear has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // Count increments, holding at all-ones; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/serial_pattern_matcher.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_matcher
// Description : Compares a serial bitstream against a run-time loadable
//               pattern and don't-care mask, in overlapping or
//               non-overlapping mode. A registered one-cycle detect pulse
//               follows the bit that completes the pattern, and only once N
//               valid bits have been captured.
//               Optional feature macro: SPM_MATCH_COUNT_EN adds a saturating
//               match counter (count_clr / match_count ports).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_matcher
  import spm_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] PATTERN_RST = N'(4'b1101),
  parameter logic [N-1:0] MASK_RST    = N'(SPM_MASK_ALL),
  parameter int           CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [N-1:0]     cfg_mask,
`ifdef SPM_MATCH_COUNT_EN
  input  logic             count_clr,
  output logic [CNT_W-1:0] match_count,
`endif
  output logic             detect
);

  localparam int           FW        = spm_fill_w(N);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  // Only the N-1 most recent bits need storing: the oldest of the N compared
  // bits is always shifted out before it could be observed again, and the
  // incoming din supplies the newest.
  logic [N-2:0]  sr_q;
  logic [FW-1:0] fill_q;
  logic [N-1:0]  pattern_q;
  logic [N-1:0]  mask_q;
  logic          detect_q;

  logic [N-1:0]  sr_d;
  logic [FW-1:0] fill_d;
  logic          hit;
  spm_ovl_e      ovl_mode;

  assign ovl_mode = spm_ovl_e'(overlap);

  // Post-shift history, saturating fill, and masked compare for this beat
  always_comb begin
    sr_d   = {sr_q, din};
    fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    hit    = din_valid && !cfg_we && (fill_d == FILL_FULL) &&
             (((sr_d ^ pattern_q) & mask_q) == '0);
  end

  // History, fill, configuration and detect pulse; cfg_we drops any
  // concurrent data beat and restarts the fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q      <= '0;
      fill_q    <= '0;
      pattern_q <= PATTERN_RST;
      mask_q    <= MASK_RST;
      detect_q  <= 1'b0;
    end else begin
      detect_q <= hit;
      if (cfg_we) begin
        pattern_q <= cfg_pattern;
        mask_q    <= cfg_mask;
        sr_q      <= '0;
        fill_q    <= '0;
      end else if (din_valid) begin
        if (hit && (ovl_mode == SPM_NONOVL)) begin
          sr_q   <= '0;
          fill_q <= '0;
        end else begin
          sr_q   <= sr_d[N-2:0];
          fill_q <= fill_d;
        end
      end
    end
  end

  assign detect = detect_q;

`ifdef SPM_MATCH_COUNT_EN
  spm_sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (count_clr),
    .inc_i   (hit),
    .count_o (match_count)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_matcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pattern_matcher
// Description : Table-driven directed bench for serial_pattern_matcher with
//               hand sequences for the optional match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_matcher;

  typedef struct packed {
    logic       rst_n;
    logic       din;
    logic       vld;
    logic       ovl;
    logic       we;
    logic [3:0] pat;
    logic [3:0] mask;
    logic       exp_det;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic [3:0] cfg_mask = 4'b1111;
  logic       detect;
`ifdef SPM_MATCH_COUNT_EN
  logic       count_clr = 1'b0;
  logic [7:0] match_count;
`endif

  int nvec = 0;
  int nerr = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  serial_pattern_matcher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .overlap     (overlap),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
`ifdef SPM_MATCH_COUNT_EN
    .count_clr   (count_clr),
    .match_count (match_count),
`endif
    .detect      (detect)
  );

  function automatic vec_t mk(input logic r, input logic d, input logic v, input logic o,
                              input logic w, input logic [3:0] p, input logic [3:0] m,
                              input logic e);
    vec_t t;
    t.rst_n = r; t.din = d; t.vld = v; t.ovl = o; t.we = w;
    t.pat = p; t.mask = m; t.exp_det = e;
    return t;
  endfunction

  // Data beat shorthand: reset released, no config write
  function automatic vec_t bt(input logic d, input logic v, input logic o, input logic e);
    return mk(1'b1, d, v, o, 1'b0, 4'b0000, 4'b0000, e);
  endfunction

  task automatic apply(input vec_t t, input string name);
    @(negedge clk);
    rst_n = t.rst_n; din = t.din; din_valid = t.vld; overlap = t.ovl;
    cfg_we = t.we; cfg_pattern = t.pat; cfg_mask = t.mask;
    @(posedge clk);
    #1;
    nvec++;
    if (detect !== t.exp_det) begin
      nerr++;
      $display("FAIL %s vec %0d: detect=%b expected %b", name, nvec, detect, t.exp_det);
    end
  endtask

`ifdef SPM_MATCH_COUNT_EN
  task automatic check_cnt(input logic [7:0] exp, input string name);
    nvec++;
    if (match_count !== exp) begin
      nerr++;
      $display("FAIL %s: match_count=%0d expected %0d", name, match_count, exp);
    end
  endtask
`endif

  initial begin
    // Reset state
    vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
    // Default pattern 1101, overlap, valid every cycle
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 0));
    vq.push_back(bt(0, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 1));
    vq.push_back(bt(1, 0, 1, 0));
    // 1101101 overlapping: hits after bits 4 and 7
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0));
    vq.push_back(bt(1, 1, 1, 1)); vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0));
    vq.push_back(bt(1, 1, 1, 1));
    // 1101101 non-overlapping: only the first hit
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0));
    vq.push_back(bt(1, 1, 0, 0)); vq.push_back(bt(1, 1, 0, 0)); vq.push_back(bt(0, 1, 0, 0));
    vq.push_back(bt(1, 1, 0, 1)); vq.push_back(bt(1, 1, 0, 0)); vq.push_back(bt(0, 1, 0, 0));
    vq.push_back(bt(1, 1, 0, 0));
    // Valid gaps: 1,(gap x3),1,0,(gap),1 with noisy din during gaps
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 0, 1, 0)); vq.push_back(bt(1, 0, 1, 0));
    vq.push_back(bt(0, 0, 1, 0)); vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0));
    vq.push_back(bt(1, 0, 1, 0)); vq.push_back(bt(1, 1, 1, 1)); vq.push_back(bt(1, 0, 1, 0));
    // Pattern 0000: fill gate, then every beat (overlap), then every 4th (non-overlap)
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0));
    vq.push_back(bt(0, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0));
    vq.push_back(bt(0, 1, 1, 1)); vq.push_back(bt(0, 1, 1, 1)); vq.push_back(bt(0, 1, 1, 1));
    vq.push_back(bt(0, 1, 0, 1)); vq.push_back(bt(0, 1, 0, 0)); vq.push_back(bt(0, 1, 0, 0));
    vq.push_back(bt(0, 1, 0, 0)); vq.push_back(bt(0, 1, 0, 1));
    // cfg_we on the completing bit of 1101 wins; then 1,0,1,x with mask 1110
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0));
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1010, 4'b1110, 1'b0));
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 0));
    vq.push_back(bt(0, 1, 1, 1));
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b1110, 1'b0));
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 0));
    vq.push_back(bt(1, 1, 1, 1));
    // Mask all zeros: hit on every valid beat once full, never on idle beats
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0110, 4'b0000, 1'b0));
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 0));
    vq.push_back(bt(1, 1, 1, 1)); vq.push_back(bt(0, 1, 1, 1)); vq.push_back(bt(0, 0, 1, 0));
    vq.push_back(bt(1, 1, 1, 1));
    // Reset mid-stream after 3 bits of 1101 discards history
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0));
    vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0));
    vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(1, 1, 1, 0)); vq.push_back(bt(0, 1, 1, 0));
    vq.push_back(bt(1, 1, 1, 1));

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], "table");
    end

`ifdef SPM_MATCH_COUNT_EN
    // Single 1101 match counts once
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0), "cnt_rst");
    check_cnt(8'd0, "cnt_after_reset");
    apply(bt(1, 1, 1, 0), "cnt_seq"); apply(bt(1, 1, 1, 0), "cnt_seq");
    apply(bt(0, 1, 1, 0), "cnt_seq"); apply(bt(1, 1, 1, 1), "cnt_seq");
    check_cnt(8'd1, "cnt_one_hit");
    // cfg_we does not clear the counter; mask 0 gives 260 hits in 263 beats
    apply(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0), "cnt_cfg");
    check_cnt(8'd1, "cnt_kept_over_cfg");
    count_clr = 1'b1;
    apply(bt(0, 0, 1, 0), "cnt_clr_idle");
    count_clr = 1'b0;
    check_cnt(8'd0, "cnt_clr");
    for (int i = 0; i < 263; i++) begin
      apply(bt(i[0], 1, 1, (i >= 3) ? 1'b1 : 1'b0), "cnt_fill");
    end
    check_cnt(8'd255, "cnt_saturate");
    count_clr = 1'b1;
    apply(bt(1, 1, 1, 1), "cnt_clr_hit");
    count_clr = 1'b0;
    check_cnt(8'd0, "cnt_clr_beats_hit");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
